// File: rtl/trellis_io_bus_pkg.sv
// Shared constants for trellis_io_bus: pad-mode names and the
// legality check applied to the DIR parameter at elaboration time.
package io_pkg;

  localparam string DIR_INPUT  = "INPUT";
  localparam string DIR_OUTPUT = "OUTPUT";
  localparam string DIR_BIDIR  = "BIDIR";

  // True when dir names one of the three supported pad modes.
  function automatic bit dir_valid(input string dir);
    return (dir == DIR_INPUT) || (dir == DIR_OUTPUT) || (dir == DIR_BIDIR);
  endfunction

endpackage

// File: rtl/trellis_io_bus_io_reg_bit.sv
// Single IOLOGIC-style flop: posedge clock, asynchronous active-high
// reset to a per-instance value (the tristate flop resets to 1 so the
// pad is released while reset is held).
module io_reg_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic q_d;
  logic q_q;

  // Next state is simply the sampled input.
  always_comb begin
    q_d = d_i;
  end

  // State flop; reset wins over the clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/trellis_io_bus.sv
// Bidirectional pad buffer with TRELLIS_IO semantics (B pad, T tristate,
// I fabric-to-pad, O pad-to-fabric) plus optional input, output and
// tristate registers. With every register disabled it is a drop-in for
// the vendor primitive.
module trellis_io_bus
  import io_pkg::*;
#(
  parameter string DIR     = "BIDIR",
  parameter int    WIDTH   = 1,
  parameter bit    IN_REG  = 1'b0,
  parameter bit    OUT_REG = 1'b0,
  parameter bit    TRI_REG = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  inout  wire  [WIDTH-1:0] B,
  input  logic             T,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O
);

  logic             t_eff;
  logic [WIDTH-1:0] i_eff;
  logic             unused_ok;

  // Depending on the mode, clock/reset and some fabric inputs have no load.
  assign unused_ok = ^{clk_i, rst_i, T, I, t_eff, i_eff};

  if (!dir_valid(DIR)) begin : g_bad_dir
    $error("trellis_io_bus: DIR=\"%s\" is not INPUT, OUTPUT or BIDIR", DIR);
  end

  // Tristate path: one enable shared by every bit.
  if (TRI_REG) begin : g_tri_reg
    logic t_q;
    io_reg_bit #(.RST_VAL(1'b1)) u_t_reg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (T),
      .q_o   (t_q)
    );
    assign t_eff = t_q;
  end else begin : g_tri_comb
    assign t_eff = T;
  end

  // Output data path, one flop per bit when registered.
  if (OUT_REG) begin : g_out_reg
    logic [WIDTH-1:0] i_q;
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      io_reg_bit #(.RST_VAL(1'b0)) u_i_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (I[k]),
        .q_o   (i_q[k])
      );
    end
    assign i_eff = i_q;
  end else begin : g_out_comb
    assign i_eff = I;
  end

  // Pad drive: an input-only pad never drives.
  if (DIR == DIR_INPUT) begin : g_pad_in
    assign B = {WIDTH{1'bz}};
  end else begin : g_pad_drv
    assign B = t_eff ? {WIDTH{1'bz}} : i_eff;
  end

  // Return path: output-only pads report 0; otherwise the (optionally
  // registered) pad value, which loops back the driven data.
  if (DIR == DIR_OUTPUT) begin : g_ret_tied
    assign O = {WIDTH{1'b0}};
  end else if (IN_REG) begin : g_ret_reg
    logic [WIDTH-1:0] o_q;
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      io_reg_bit #(.RST_VAL(1'b0)) u_o_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (B[k]),
        .q_o   (o_q[k])
      );
    end
    assign O = o_q;
  end else begin : g_ret_comb
    assign O = B;
  end

endmodule

// File: tb/tb_trellis_io_bus.sv
// Directed bench for trellis_io_bus: four instances cover the
// unregistered BIDIR, INPUT and OUTPUT modes and a fully registered
// BIDIR pad sharing one clock and reset.
module tb_trellis_io_bus;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Unregistered BIDIR pad with an external driver.
  logic       t_bi = 1'b1;
  logic [7:0] i_bi = 8'h00;
  logic [7:0] o_bi;
  logic       ext_bi_en = 1'b0;
  logic [7:0] ext_bi_val = 8'h00;
  wire  [7:0] b_bi;
  assign b_bi = ext_bi_en ? ext_bi_val : 8'hzz;

  trellis_io_bus #(.DIR("BIDIR"), .WIDTH(8), .IN_REG(1'b0), .OUT_REG(1'b0), .TRI_REG(1'b0)) u_bidir (
    .clk_i(clk), .rst_i(rst), .B(b_bi), .T(t_bi), .I(i_bi), .O(o_bi));

  // INPUT pad with an external driver.
  logic       t_in = 1'b0;
  logic [7:0] i_in = 8'h55;
  logic [7:0] o_in;
  logic       ext_in_en = 1'b0;
  wire  [7:0] b_in;
  assign b_in = ext_in_en ? 8'h81 : 8'hzz;

  trellis_io_bus #(.DIR("INPUT"), .WIDTH(8), .IN_REG(1'b0), .OUT_REG(1'b0), .TRI_REG(1'b0)) u_in (
    .clk_i(clk), .rst_i(rst), .B(b_in), .T(t_in), .I(i_in), .O(o_in));

  // OUTPUT pad, nothing else on the net.
  logic       t_out = 1'b0;
  logic [7:0] i_out = 8'h55;
  logic [7:0] o_out;
  wire  [7:0] b_out;

  trellis_io_bus #(.DIR("OUTPUT"), .WIDTH(8), .IN_REG(1'b0), .OUT_REG(1'b0), .TRI_REG(1'b0)) u_out (
    .clk_i(clk), .rst_i(rst), .B(b_out), .T(t_out), .I(i_out), .O(o_out));

  // Fully registered BIDIR pad, nothing else on the net.
  logic       t_rg = 1'b1;
  logic [7:0] i_rg = 8'h00;
  logic [7:0] o_rg;
  wire  [7:0] b_rg;

  trellis_io_bus #(.DIR("BIDIR"), .WIDTH(8), .IN_REG(1'b1), .OUT_REG(1'b1), .TRI_REG(1'b1)) u_reg (
    .clk_i(clk), .rst_i(rst), .B(b_rg), .T(t_rg), .I(i_rg), .O(o_rg));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Unregistered BIDIR: drive, loopback.
    t_bi = 1'b0; i_bi = 8'hA5; #1;
    chk("bidir_drive_B", b_bi, 8'hA5);
    chk("bidir_drive_O", o_bi, 8'hA5);
    i_bi = 8'h5A; #1;
    chk("bidir_loop_O", o_bi, 8'h5A);

    // Released, external driver owns the net.
    t_bi = 1'b1; ext_bi_en = 1'b1; ext_bi_val = 8'h3C; #1;
    chk("bidir_ext_B", b_bi, 8'h3C);
    chk("bidir_ext_O", o_bi, 8'h3C);

    // Released and undriven while I toggles.
    ext_bi_en = 1'b0; i_bi = 8'h00; #1;
    vectors++;
    assert (b_bi === 8'hzz) else begin
      miscompares++;
      $error("FAIL bidir_rel_00: observed %h expected zz", b_bi);
    end
    i_bi = 8'hFF; #1;
    vectors++;
    assert (b_bi === 8'hzz) else begin
      miscompares++;
      $error("FAIL bidir_rel_FF: observed %h expected zz", b_bi);
    end

    // INPUT mode never drives.
    ext_in_en = 1'b1; #1;
    chk("input_B", b_in, 8'h81);
    chk("input_O", o_in, 8'h81);

    // OUTPUT mode drives, O tied low, releases on T=1.
    chk("output_B", b_out, 8'h55);
    chk("output_O", o_out, 8'h00);
    t_out = 1'b1; #1;
    vectors++;
    assert (b_out === 8'hzz) else begin
      miscompares++;
      $error("FAIL output_rel: observed %h expected zz", b_out);
    end

    // Registered pad held in reset.
    @(posedge clk); #1;
    vectors++;
    assert (b_rg === 8'hzz) else begin
      miscompares++;
      $error("FAIL reg_rst_B: observed %h expected zz", b_rg);
    end
    chk("reg_rst_O", o_rg, 8'h00);

    // Release reset and request drive of 8'h12 in the same cycle.
    @(negedge clk);
    rst = 1'b0; t_rg = 1'b0; i_rg = 8'h12; #1;
    vectors++;
    assert (b_rg === 8'hzz) else begin
      miscompares++;
      $error("FAIL reg_pre_edge_B: observed %h expected zz", b_rg);
    end
    @(posedge clk); #1;
    chk("reg_drive_B", b_rg, 8'h12);
    @(posedge clk); #1;
    chk("reg_drive_O", o_rg, 8'h12);

    // New data 8'hC3: pad after one edge, O after another.
    @(negedge clk);
    i_rg = 8'hC3;
    @(posedge clk); #1;
    chk("reg_c3_B", b_rg, 8'hC3);
    @(posedge clk); #1;
    chk("reg_c3_O", o_rg, 8'hC3);

    // Asynchronous reset between edges.
    @(negedge clk);
    rst = 1'b1; #1;
    vectors++;
    assert (b_rg === 8'hzz) else begin
      miscompares++;
      $error("FAIL reg_async_B: observed %h expected zz", b_rg);
    end
    chk("reg_async_O", o_rg, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
